// File: rtl/avlst_pkg.sv
// Shared definitions for the Avalon-ST width-conversion blocks:
// index-width helper and lane-order constants.
package avlst_pkg;

   typedef enum logic {
      LANE_LSB_FIRST = 1'b0,
      LANE_MSB_FIRST = 1'b1
   } lane_order_e;

   // Lane indices and empty counts are always at least one bit wide,
   // so a single-lane configuration still has legal ports.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Every block sizes its lane-index signals with this helper.
   function automatic int lane_idx_w(input int n);
      return clog2_min1(n);
   endfunction

endpackage

// File: rtl/avlst_lane_sel.sv
// Combinational N:1 lane multiplexer with an optional lane-order reversal.
module avlst_lane_sel
   import avlst_pkg::*;
#(
   parameter int N         = 8,
   parameter int DATA_W    = 16,
   parameter int MSB_FIRST = 0,
   localparam int IDX_W    = lane_idx_w(N)
) (
   input  logic [N*DATA_W-1:0] word,
   input  logic [IDX_W-1:0]    idx,
   output logic [DATA_W-1:0]   lane
);

   localparam bit REVERSE = (MSB_FIRST == int'(LANE_MSB_FIRST));
   localparam logic [IDX_W-1:0] TOP_LANE = IDX_W'(N - 1);

   logic [IDX_W-1:0] sel;

   always_comb begin
      sel = REVERSE ? (TOP_LANE - idx) : idx;
      // NOTE: default assignment first so no path leaves lane unassigned (no latch).
      lane = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == IDX_W'(i)) begin
            lane = word[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/avlst_n_to_1_pkt.sv
// Avalon-ST wide-to-narrow serialiser: one N-lane word in, up to N beats out,
// with packet framing, tail-empty trimming and bubble-free back-to-back words.
module avlst_n_to_1_pkt
   import avlst_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_W     = 16,
   parameter int MSB_FIRST  = 0,
   localparam int EMPTY_W   = clog2_min1(N)
) (
   input  logic                csi_clk,
   input  logic                rsi_reset_n,
   output logic                asi_ready,
   input  logic                asi_valid,
   input  logic [N*DATA_W-1:0] asi_data,
   input  logic                asi_startofpacket,
   input  logic                asi_endofpacket,
   input  logic [EMPTY_W-1:0]  asi_empty,
   input  logic                aso_ready,
   output logic                aso_valid,
   output logic [DATA_W-1:0]   aso_data,
   output logic                aso_startofpacket,
   output logic                aso_endofpacket
);

   localparam int IDX_W = lane_idx_w(N);
   localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N - 1);

   logic [N*DATA_W-1:0] word_q;
   logic                sop_q;
   logic                eop_q;
   logic [IDX_W-1:0]    last_q;
   logic [IDX_W-1:0]    cnt_q;
   logic                valid_q;

   logic [IDX_W-1:0]    eff_empty;
   logic                last_hit;
   logic                load;

   assign last_hit  = (cnt_q == last_q);
   assign asi_ready = !valid_q | (aso_ready & last_hit);
   assign load      = asi_valid & asi_ready;

   // Oversized empty values clamp to N-1 so at least one beat always leaves.
   always_comb begin
      eff_empty = '0;
      if (asi_endofpacket) begin
         eff_empty = (asi_empty > LAST_LANE) ? LAST_LANE : asi_empty;
      end
   end

   // NOTE: non-blocking assignments for all state; word_q is reset too so
   // aso_data reads zero rather than X before the first word.
   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         word_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         last_q  <= LAST_LANE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         word_q  <= asi_data;
         sop_q   <= asi_startofpacket;
         eop_q   <= asi_endofpacket;
         last_q  <= LAST_LANE - eff_empty;
         cnt_q   <= '0;
         valid_q <= 1'b1;
      end else if (valid_q && aso_ready) begin
         if (last_hit) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
         end else begin
            cnt_q   <= cnt_q + IDX_W'(1);
         end
      end
   end

   avlst_lane_sel #(
      .N         (N),
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_lane_sel (
      .word (word_q),
      .idx  (cnt_q),
      .lane (aso_data)
   );

   assign aso_valid         = valid_q;
   assign aso_startofpacket = valid_q & sop_q & (cnt_q == '0);
   assign aso_endofpacket   = valid_q & eop_q & last_hit;

endmodule

// File: tb/tb_avlst_n_to_1_pkt.sv
// Bench for avlst_n_to_1_pkt: LSB-first and MSB-first N=4 instances share
// stimulus, plus an N=3 instance for empty clamping; beats go through scoreboards.
module tb_avlst_n_to_1_pkt;

   typedef struct {
      logic [31:0]     data;
      logic            sop;
      logic            eop;
      logic [1:0]      empty;
      int              n;
      logic [3:0][7:0] exp_lsb;
      logic [3:0][7:0] exp_msb;
      logic            gap;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        aso_ready;
   logic        asi_valid, asi_sop, asi_eop;
   logic [31:0] asi_data;
   logic [1:0]  asi_empty;
   logic        ready_a, valid_a, sop_a, eop_a;
   logic [7:0]  data_a;
   logic        ready_b, valid_b, sop_b, eop_b;
   logic [7:0]  data_b;

   logic        c_valid, c_sop, c_eop;
   logic [23:0] c_data;
   logic [1:0]  c_empty;
   logic        ready_c, valid_c, sop_c, eop_c;
   logic [7:0]  data_c;

   avlst_n_to_1_pkt #(.N(4), .DATA_W(8), .MSB_FIRST(0)) dut_a (
      .csi_clk(clk), .rsi_reset_n(rst_n), .asi_ready(ready_a), .asi_valid(asi_valid),
      .asi_data(asi_data), .asi_startofpacket(asi_sop), .asi_endofpacket(asi_eop),
      .asi_empty(asi_empty), .aso_ready(aso_ready), .aso_valid(valid_a), .aso_data(data_a),
      .aso_startofpacket(sop_a), .aso_endofpacket(eop_a));

   avlst_n_to_1_pkt #(.N(4), .DATA_W(8), .MSB_FIRST(1)) dut_b (
      .csi_clk(clk), .rsi_reset_n(rst_n), .asi_ready(ready_b), .asi_valid(asi_valid),
      .asi_data(asi_data), .asi_startofpacket(asi_sop), .asi_endofpacket(asi_eop),
      .asi_empty(asi_empty), .aso_ready(aso_ready), .aso_valid(valid_b), .aso_data(data_b),
      .aso_startofpacket(sop_b), .aso_endofpacket(eop_b));

   avlst_n_to_1_pkt #(.N(3), .DATA_W(8), .MSB_FIRST(0)) dut_c (
      .csi_clk(clk), .rsi_reset_n(rst_n), .asi_ready(ready_c), .asi_valid(c_valid),
      .asi_data(c_data), .asi_startofpacket(c_sop), .asi_endofpacket(c_eop),
      .asi_empty(c_empty), .aso_ready(aso_ready), .aso_valid(valid_c), .aso_data(data_c),
      .aso_startofpacket(sop_c), .aso_endofpacket(eop_c));

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   beat_t q_a[$], q_b[$], q_c[$];
   int    times_a[$];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic no_beat_expected(input string name, input logic [7:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got beat %0h expected none (t=%0t)", name, act, $time);
   endtask

   // Scoreboard monitors: sample at the falling edge, opposite the active edge.
   logic       stall_a = 1'b0;
   logic [7:0] st_data;
   logic       st_sop, st_eop;

   always @(negedge clk) begin
      beat_t b;
      if (rst_n && valid_a) begin
         if (stall_a) begin
            check("a_stall_data", data_a, st_data);
            check("a_stall_sop", sop_a, st_sop);
            check("a_stall_eop", eop_a, st_eop);
         end
         if (aso_ready) begin
            stall_a = 1'b0;
            if (q_a.size() == 0) no_beat_expected("a_unexpected", data_a);
            else begin
               b = q_a.pop_front();
               check("a_data", data_a, b.data);
               check("a_sop", sop_a, b.sop);
               check("a_eop", eop_a, b.eop);
               check("a_asi_ready", ready_a, b.last);
               times_a.push_back(cyc);
            end
         end else begin
            check("a_ready_in_stall", ready_a, 1'b0);
            stall_a = 1'b1;
            st_data = data_a;
            st_sop  = sop_a;
            st_eop  = eop_a;
         end
      end else begin
         stall_a = 1'b0;
      end
   end

   always @(negedge clk) begin
      beat_t b;
      if (rst_n && valid_b && aso_ready) begin
         if (q_b.size() == 0) no_beat_expected("b_unexpected", data_b);
         else begin
            b = q_b.pop_front();
            check("b_data", data_b, b.data);
            check("b_sop", sop_b, b.sop);
            check("b_eop", eop_b, b.eop);
            check("b_asi_ready", ready_b, b.last);
         end
      end
   end

   always @(negedge clk) begin
      beat_t b;
      if (rst_n && valid_c && aso_ready) begin
         if (q_c.size() == 0) no_beat_expected("c_unexpected", data_c);
         else begin
            b = q_c.pop_front();
            check("c_data", data_c, b.data);
            check("c_sop", sop_c, b.sop);
            check("c_eop", eop_c, b.eop);
            check("c_asi_ready", ready_c, b.last);
         end
      end
   end

   task automatic send_vec(input vec_t v);
      beat_t b;
      int    n;
      asi_valid = 1'b1;
      asi_data  = v.data;
      asi_sop   = v.sop;
      asi_eop   = v.eop;
      asi_empty = v.empty;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_a && n < 50);
      checks++;
      if (!ready_a) begin
         errors++;
         $display("FAIL send_timeout: asi_ready still 0 after %0d cycles, required 1", n);
      end
      for (int i = 0; i < v.n; i++) begin
         b.sop  = v.sop && (i == 0);
         b.eop  = v.eop && (i == v.n - 1);
         b.last = (i == v.n - 1);
         b.data = v.exp_lsb[i];
         q_a.push_back(b);
         b.data = v.exp_msb[i];
         q_b.push_back(b);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_c(input logic [23:0] d, input logic s, input logic e,
                         input logic [1:0] emp, input int nb, input logic [2:0][7:0] exp);
      beat_t b;
      int    n;
      c_valid = 1'b1;
      c_data  = d;
      c_sop   = s;
      c_eop   = e;
      c_empty = emp;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_c && n < 50);
      checks++;
      if (!ready_c) begin
         errors++;
         $display("FAIL send_c_timeout: asi_ready still 0 after %0d cycles, required 1", n);
      end
      for (int i = 0; i < nb; i++) begin
         b.data = exp[i];
         b.sop  = s && (i == 0);
         b.eop  = e && (i == nb - 1);
         b.last = (i == nb - 1);
         q_c.push_back(b);
      end
      @(posedge clk);
      #1;
      c_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d beats outstanding, required 0",
                  q_a.size() + q_b.size() + q_c.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   vec_t       vecs[6];
   int         total;
   logic [3:0] pat;

   initial begin
      vecs[0] = '{data:32'h44332211, sop:1'b1, eop:1'b1, empty:2'd0, n:4,
                  exp_lsb:32'h44332211, exp_msb:32'h11223344, gap:1'b1};
      vecs[1] = '{data:32'h44332211, sop:1'b1, eop:1'b0, empty:2'd0, n:4,
                  exp_lsb:32'h44332211, exp_msb:32'h11223344, gap:1'b0};
      vecs[2] = '{data:32'h88776655, sop:1'b0, eop:1'b1, empty:2'd0, n:4,
                  exp_lsb:32'h88776655, exp_msb:32'h55667788, gap:1'b1};
      vecs[3] = '{data:32'hDDCCBBAA, sop:1'b1, eop:1'b1, empty:2'd2, n:2,
                  exp_lsb:32'h0000BBAA, exp_msb:32'h0000CCDD, gap:1'b1};
      vecs[4] = '{data:32'hDDCCBBAA, sop:1'b1, eop:1'b0, empty:2'd2, n:4,
                  exp_lsb:32'hDDCCBBAA, exp_msb:32'hAABBCCDD, gap:1'b1};
      vecs[5] = '{data:32'h0F0E0D0C, sop:1'b1, eop:1'b1, empty:2'd3, n:1,
                  exp_lsb:32'h0000000C, exp_msb:32'h0000000F, gap:1'b1};

      // Reset with a valid word presented: nothing may load.
      rst_n     = 1'b0;
      aso_ready = 1'b1;
      asi_valid = 1'b1;
      asi_data  = 32'hCAFEF00D;
      asi_sop   = 1'b1;
      asi_eop   = 1'b1;
      asi_empty = 2'd0;
      c_valid   = 1'b0;
      c_data    = '0;
      c_sop     = 1'b0;
      c_eop     = 1'b0;
      c_empty   = '0;
      repeat (3) @(negedge clk);
      check("rst_aso_valid", valid_a, 1'b0);
      check("rst_asi_ready", ready_a, 1'b1);
      check("rst_aso_data", data_a, 8'h00);
      check("rst_sop_eop", {sop_a, eop_a}, 2'b00);
      asi_valid = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      check("post_rst_idle", valid_a | valid_b, 1'b0);
      @(posedge clk);
      #1;

      // Table: bubble-free groups of words with full downstream readiness.
      times_a.delete();
      total = 0;
      for (int i = 0; i < 6; i++) begin
         send_vec(vecs[i]);
         total += vecs[i].n;
         if (vecs[i].gap) begin
            asi_valid = 1'b0;
            wait_drain();
            check("group_beats", times_a.size(), total);
            if (times_a.size() == total)
               check("group_no_bubble", times_a[total-1] - times_a[0], total - 1);
            times_a.delete();
            total = 0;
         end
      end

      // Backpressure: aso_ready pattern 1,0,0,1 while one word drains.
      pat = 4'b1001;
      send_vec(vecs[0]);
      asi_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         aso_ready = pat[i % 4];
         @(posedge clk);
         #1;
      end
      aso_ready = 1'b1;
      wait_drain();

      // Reset after two of four lanes: remainder is discarded.
      send_vec(vecs[0]);
      asi_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid_a", valid_a, 1'b0);
      check("midrst_valid_b", valid_b, 1'b0);
      check("midrst_ready", ready_a, 1'b1);
      q_a.delete();
      q_b.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_no_beat", valid_a, 1'b0);
      send_vec(vecs[0]);
      asi_valid = 1'b0;
      wait_drain();

      // N=3: empty=3 clamps to 2 (one beat); empty=1 gives two beats.
      send_c(24'h332211, 1'b1, 1'b1, 2'd3, 1, 24'h000011);
      wait_drain();
      send_c(24'h665544, 1'b1, 1'b1, 2'd1, 2, 24'h005544);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/avlst_n_to_1_pkt.md
Name: avlst_n_to_1_pkt

Overview:
Parametrised Avalon-ST wide-to-narrow serialiser. Accepts one N-lane word of N*DATA_W bits and emits it as N (or fewer) DATA_W-bit beats. Carries packet framing (startofpacket/endofpacket/empty) and allows selectable lane order. Input is accepted on the cycle the last lane leaves, so the output streams one lane per cycle with no bubbles. Sits between wide internal datapaths and narrow sink interfaces.

Parameters:
N, 8, number of lanes per input word (N >= 1, any integer).
DATA_W, 16, width of one lane / output beat in bits.
MSB_FIRST, 0, 0 = lane 0 (bits DATA_W-1:0) is emitted first; 1 = lane N-1 is emitted first.
EMPTY_W, max(1,clog2(N)), width of asi_empty; derived, not for override.

Ports:
csi_clk  in  1  clock; all logic on its rising edge.
rsi_reset_n  in  1  asynchronous active-low reset.
asi_ready  out  1  sink ready (readyLatency 0).
asi_valid  in  1  input word valid.
asi_data  in  N*DATA_W  input word; lane i = bits (i+1)*DATA_W-1 : i*DATA_W.
asi_startofpacket  in  1  word is the first of a packet.
asi_endofpacket  in  1  word is the last of a packet.
asi_empty  in  EMPTY_W  unused lanes at the tail of the emission order; honoured only with endofpacket.
aso_ready  in  1  downstream ready (readyLatency 0).
aso_valid  out  1  output beat valid.
aso_data  out  DATA_W  output lane.
aso_startofpacket  out  1  first beat of a packet.
aso_endofpacket  out  1  last beat of a packet.

Behaviour:
- Clock is csi_clk; reset is asynchronous, active-low (rsi_reset_n).
- State: word_q, sop_q, eop_q, last_q (lane index), cnt_q (lane index), valid_q.
- Reset: valid_q=0, cnt_q=0, word_q=0, sop_q=eop_q=0, last_q=N-1. Outputs during reset: aso_valid=0, aso_data=0, aso_sop=aso_eop=0, asi_ready=1.
- asi_ready = !valid_q | (aso_ready & cnt_q==last_q). Combinational from aso_ready; no path from asi_valid.
- Load (asi_valid & asi_ready): word_q<=asi_data, sop_q<=asi_sop, eop_q<=asi_eop, cnt_q<=0, valid_q<=1, last_q<=N-1-eff_empty.
- eff_empty = asi_endofpacket ? min(asi_empty, N-1) : 0. Out-of-range empty is clamped, never wraps.
- Drain (valid_q & aso_ready, no load): if cnt_q==last_q then valid_q<=0, cnt_q<=0; else cnt_q<=cnt_q+1.
- If the last lane leaves and a load happens in the same cycle, the load wins. The next beat is lane 0 of the new word, with no idle cycle.
- Latency: a word accepted at edge k presents its first lane at aso_data after edge k. Sustained throughput is 1 beat/cycle.
- aso_valid=valid_q. aso_data = word_q lane L, where L = cnt_q (MSB_FIRST=0) or N-1-cnt_q (MSB_FIRST=1).
- aso_startofpacket = valid_q & sop_q & cnt_q==0. aso_endofpacket = valid_q & eop_q & cnt_q==last_q.
- Backpressure: while aso_valid & !aso_ready, aso_data, aso_sop and aso_eop hold stable and cnt_q does not move.
- No packet-protocol checking. sop/eop are passed through as presented.
- Reset mid-word: the partially emitted word is discarded. No beat is emitted after reset until a new load.
- N=1: pass-through register with 1-cycle latency and full throughput. cnt_q is constant 0 and empty is ignored.

Decomposition:
- Package avlst_pkg holds:
  - the clog2/max(1,clog2) helper for lane-index and empty widths;
  - the lane-index width localparam convention;
  - the lane-order enum constants LANE_LSB_FIRST=0 and LANE_MSB_FIRST=1.
- One sub-module, avlst_lane_sel. It is a combinational N:1 lane mux with a MSB_FIRST reversal and is reused by future 1-to-N/N-to-M blocks. Control and state stay in the top module.

Test Plan:
- Reset then idle, N=4, DATA_W=8: aso_valid=0, asi_ready=1, aso_data=0. asi_valid pulsed while rsi_reset_n=0 → no load.
- Single word, aso_ready=1: data 0x44332211, sop=1, eop=1, empty=0 → beats 11,22,33,44 on four consecutive cycles. sop on 11, eop on 44. asi_ready=1 only in the 44 cycle.
- Back-to-back words 0x44332211 then 0x88776655 held valid → eight beats 11..88 on eight consecutive cycles with no bubble. Repeat with MSB_FIRST=1 → 44,33,22,11,88,77,66,55.
- Empty handling: eop=1, empty=2, data 0xDDCCBBAA → beats AA,BB, eop on BB, asi_ready on BB's cycle. empty=2 with eop=0 → all four lanes emitted. N=3 with empty=3 → clamped, 1 beat.
- Backpressure: aso_ready toggled 1,0,0,1,... during a word → aso_data and sop/eop stable while stalled, all four lanes emitted exactly once and in order, asi_ready=0 while stalled on the last lane.
- Reset mid-word: reset asserted after 2 of 4 lanes, then released → aso_valid=0 immediately (async). The next word starts at lane 0 with sop.
